cpu_bus_interconnect: RTL and testbench
=======================================

# cpu_bus_interconnect

Single-master interconnect between the CPU data/instruction bus and the on-chip CPU peripherals: bootloader ROM, RAM, flash window, config registers and UART. It decodes the upper address nibble and forwards each transaction to exactly one device. It returns that device's read data and acknowledge to the CPU. Unmapped and (optionally) stalled accesses are terminated with an error response, so the CPU never hangs waiting for an ack.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1023: maximum cycles a device may take to ack before forced termination.
- ERROR_RDATA, default 32'h0000_0000: read data returned on error termination.

Ports:
- sys.clk  input  1  system clock; all logic on rising edge.
- sys.reset  input  1  reset; synchronous, active-high.
- bus.request  input  1  CPU access request; held high until bus.ack.
- bus.address  input  32  byte address.
- bus.wdata  input  32  write data.
- bus.wmask  input  4  byte write enables; 4'h0 = read.
- bus.ack  output  1  one-cycle completion strobe.
- bus.rdata  output  32  read data, valid while bus.ack.
- dev_request  output  5  one-hot request to device i.
- dev_address  output  32  latched address, shared.
- dev_wdata  output  32  latched write data, shared.
- dev_wmask  output  4  latched write mask, shared.
- dev_ack  input  5  per-device ack.
- dev_rdata  input  5x32  per-device read data.
- err_pulse  output  1  one-cycle strobe on any error termination.
- err_timeout  output  1  qualifies err_pulse: 1 = timeout, 0 = unmapped.
- err_address  output  32  address of most recent errored access.

## Operation
- Region map on address[31:28]:
  - 0x0 RAM (dev 0)
  - 0x1 FLASH (dev 1)
  - 0x2 CFG (dev 2)
  - 0x5 UART (dev 3)
  - 0xF BOOTLOADER (dev 4)
  - All other regions are unmapped.
- States: IDLE, ACCESS, RESPOND.
- IDLE with bus.request=1:
  - Latch address, wdata and wmask.
  - Mapped region: set dev_request[i], go to ACCESS, clear timeout counter.
  - Unmapped region: go to RESPOND with ERROR_RDATA, err_pulse=1, err_timeout=0.
- ACCESS:
  - dev_request[i] is held until dev_ack[i]=1, then dropped.
  - On dev_ack[i]=1: capture dev_rdata[i], go to RESPOND.
  - dev_ack from any non-selected device is ignored.
- RESPOND: bus.ack=1 for exactly one cycle, then IDLE. bus.request in the RESPOND cycle is ignored; the master drops it upon sampling ack.
- Writes: rdata content is don't-care; error handling is identical to reads.
- err_address updates on every error and holds otherwise. err_timeout holds its last value.

## Timing
- Reset values:
  - state: IDLE
  - dev_request: 0
  - bus.ack: 0
  - bus.rdata: 0
  - err_pulse: 0
  - err_timeout: 0
  - err_address: 0
  - latched address/wdata/wmask: 0
- Request sampled in cycle 0 → dev_request high in cycle 1.
- Device ack in cycle n → bus.ack in cycle n+1.
- Single-cycle device (acks in the cycle after its request): bus.ack in cycle 3.
- Unmapped access: bus.ack in cycle 1.
- Back-to-back: a new request is accepted the cycle after RESPOND, i.e. 1 idle cycle minimum between acks.
- dev_ack coincident with timeout expiry: the ack wins; normal response, no error.
- Reset mid-ACCESS: dev_request drops in the next cycle. The outstanding device response is discarded and bus.ack is not issued.
- dev_ack arriving while in IDLE: ignored.

## Configuration
- CPU_BUS_TIMEOUT_EN defined:
  - A counter increments each ACCESS cycle.
  - When the counter reaches TIMEOUT_CYCLES with no ack: dev_request drops, go to RESPOND with ERROR_RDATA, err_pulse=1, err_timeout=1.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter; ACCESS waits indefinitely. err_timeout is tied 0.

## Structure
- Package cpu_bus_pkg holds:
  - device enum (DEV_RAM, DEV_FLASH, DEV_CFG, DEV_UART, DEV_BOOTLOADER)
  - NUM_DEVICES = 5
  - region code localparams
  - the address-decode function, returning index plus valid flag
- Sub-module cpu_bus_watchdog holds the timeout counter (clear, enable, expired), instantiated only under CPU_BUS_TIMEOUT_EN.

## Test plan
- Read 0xF000_0008, bootloader model acking 1 cycle after request with rdata 32'h5000_0637 → dev_request=5'b10000 in cycle 1; bus.ack in cycle 3 with rdata 32'h5000_0637.
- Write 0x0000_0100, wdata 32'hCAFE_F00D, wmask 4'hF → dev_request[0], dev_wdata=32'hCAFE_F00D, dev_wmask=4'hF; single bus.ack.
- Read 0x3000_0000 (unmapped) → bus.ack in cycle 1, rdata ERROR_RDATA, err_pulse=1, err_timeout=0, err_address=32'h3000_0000; no dev_request.
- With CPU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, UART never acks → after 16 ACCESS cycles dev_request drops; bus.ack with err_pulse=1, err_timeout=1.
- Stray dev_ack[2] during a RAM access, then sys.reset asserted mid-ACCESS → stray ack ignored; after reset all outputs at reset values and no bus.ack.
- Back-to-back reads to 0x0 then 0x5 → exactly two acks, one idle cycle between them, correct rdata each.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared types, region codes and address decode for the CPU
//               bus interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_bus_pkg;

  localparam int NUM_DEVICES = 5;

  // Device indices; the value doubles as the bit position in dev_request.
  typedef enum logic [2:0] {
    DEV_RAM        = 3'd0,
    DEV_FLASH      = 3'd1,
    DEV_CFG        = 3'd2,
    DEV_UART       = 3'd3,
    DEV_BOOTLOADER = 3'd4
  } dev_e;

  // Interconnect FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  // Region codes taken from address[31:28].
  localparam logic [3:0] C_REGION_RAM        = 4'h0;
  localparam logic [3:0] C_REGION_FLASH      = 4'h1;
  localparam logic [3:0] C_REGION_CFG        = 4'h2;
  localparam logic [3:0] C_REGION_UART       = 4'h5;
  localparam logic [3:0] C_REGION_BOOTLOADER = 4'hF;

  typedef struct packed {
    logic valid;
    dev_e dev;
  } decode_t;

  // Map a region nibble to its device; valid=0 for unmapped regions.
  function automatic decode_t decode_region(input logic [3:0] region);
    decode_t d;
    d.valid = 1'b1;
    d.dev   = DEV_RAM;
    case (region)
      C_REGION_RAM:        d.dev = DEV_RAM;
      C_REGION_FLASH:      d.dev = DEV_FLASH;
      C_REGION_CFG:        d.dev = DEV_CFG;
      C_REGION_UART:       d.dev = DEV_UART;
      C_REGION_BOOTLOADER: d.dev = DEV_BOOTLOADER;
      default:             d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_bus_watchdog.sv
// ============================================================================
// Module      : cpu_bus_watchdog
// Description : Access timeout counter. Cleared while idle, counts each
//               enabled cycle, flags expiry on the cycle in which the count
//               would reach TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LIMIT      = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Count enabled cycles, saturating at the limit; clear restarts from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is flagged in the cycle whose increment reaches the limit, so the
  // access is terminated after exactly TIMEOUT_CYCLES enabled cycles.
  assign expired = enable && (r_count == C_LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/cpu_bus_interconnect.sv
// ============================================================================
// Module      : cpu_bus_interconnect
// Description : Single-master CPU bus to peripheral interconnect. Decodes
//               address[31:28], forwards the access to one device and returns
//               its response; unmapped (and, with CPU_BUS_TIMEOUT_EN defined,
//               timed-out) accesses are terminated with an error response.
// Config      : CPU_BUS_TIMEOUT_EN - enables the access timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_interconnect
  import cpu_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERROR_RDATA    = 32'h0000_0000
) (
  input  logic         sys_clk,
  input  logic         sys_reset,
  input  logic         bus_request,
  input  logic [31:0]  bus_address,
  input  logic [31:0]  bus_wdata,
  input  logic [3:0]   bus_wmask,
  output logic         bus_ack,
  output logic [31:0]  bus_rdata,
  output logic [4:0]   dev_request,
  output logic [31:0]  dev_address,
  output logic [31:0]  dev_wdata,
  output logic [3:0]   dev_wmask,
  input  logic [4:0]   dev_ack,
  input  logic [159:0] dev_rdata,
  output logic         err_pulse,
  output logic         err_timeout,
  output logic [31:0]  err_address
);

  state_e        r_state;
  state_e        w_state_next;
  dev_e          r_sel;
  dev_e          w_sel_next;
  logic [4:0]    r_dev_request, w_dev_request_next;
  logic          r_ack, w_ack_next;
  logic [31:0]   r_rdata, w_rdata_next;
  logic          r_err_pulse, w_err_pulse_next;
  logic          r_err_timeout, w_err_timeout_next;
  logic [31:0]   r_err_address, w_err_address_next;
  logic [31:0]   r_address, w_address_next;
  logic [31:0]   r_wdata, w_wdata_next;
  logic [3:0]    r_wmask, w_wmask_next;

  decode_t       w_decode;
  logic          w_sel_ack;
  logic [31:0]   w_sel_rdata;
  logic          w_expired;

  assign w_decode    = decode_region(bus_address[31:28]);
  assign w_sel_ack   = dev_ack[r_sel];
  assign w_sel_rdata = dev_rdata[int'(r_sel)*32 +: 32];

`ifdef CPU_BUS_TIMEOUT_EN
  // Counter is held clear outside ACCESS so each access starts from zero.
  cpu_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (sys_clk),
    .rst     (sys_reset),
    .clear   (r_state != ST_ACCESS),
    .enable  (r_state == ST_ACCESS),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // State and output registers; everything returns to zero on reset, which
  // also discards any outstanding device response.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state       <= ST_IDLE;
      r_sel         <= DEV_RAM;
      r_dev_request <= '0;
      r_ack         <= 1'b0;
      r_rdata       <= '0;
      r_err_pulse   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_address <= '0;
      r_address     <= '0;
      r_wdata       <= '0;
      r_wmask       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_sel         <= w_sel_next;
      r_dev_request <= w_dev_request_next;
      r_ack         <= w_ack_next;
      r_rdata       <= w_rdata_next;
      r_err_pulse   <= w_err_pulse_next;
      r_err_timeout <= w_err_timeout_next;
      r_err_address <= w_err_address_next;
      r_address     <= w_address_next;
      r_wdata       <= w_wdata_next;
      r_wmask       <= w_wmask_next;
    end
  end

  // Next-state and next-output logic; ack and err_pulse are single-cycle
  // strobes that default low, everything else holds.
  always_comb begin
    w_state_next       = r_state;
    w_sel_next         = r_sel;
    w_dev_request_next = r_dev_request;
    w_ack_next         = 1'b0;
    w_rdata_next       = r_rdata;
    w_err_pulse_next   = 1'b0;
    w_err_timeout_next = r_err_timeout;
    w_err_address_next = r_err_address;
    w_address_next     = r_address;
    w_wdata_next       = r_wdata;
    w_wmask_next       = r_wmask;

    case (r_state)
      ST_IDLE: begin
        if (bus_request) begin
          w_address_next = bus_address;
          w_wdata_next   = bus_wdata;
          w_wmask_next   = bus_wmask;
          if (w_decode.valid) begin
            w_sel_next         = w_decode.dev;
            w_dev_request_next = 5'(1) << w_decode.dev;
            w_state_next       = ST_ACCESS;
          end else begin
            w_rdata_next       = ERROR_RDATA;
            w_ack_next         = 1'b1;
            w_err_pulse_next   = 1'b1;
            w_err_timeout_next = 1'b0;
            w_err_address_next = bus_address;
            w_state_next       = ST_RESPOND;
          end
        end
      end

      ST_ACCESS: begin
        // An ack coincident with expiry wins: normal completion, no error.
        if (w_sel_ack) begin
          w_rdata_next       = w_sel_rdata;
          w_dev_request_next = '0;
          w_ack_next         = 1'b1;
          w_state_next       = ST_RESPOND;
        end else if (w_expired) begin
          w_rdata_next       = ERROR_RDATA;
          w_dev_request_next = '0;
          w_ack_next         = 1'b1;
          w_err_pulse_next   = 1'b1;
          w_err_timeout_next = 1'b1;
          w_err_address_next = r_address;
          w_state_next       = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next       = ST_IDLE;
        w_dev_request_next = '0;
      end
    endcase
  end

  assign bus_ack     = r_ack;
  assign bus_rdata   = r_rdata;
  assign dev_request = r_dev_request;
  assign dev_address = r_address;
  assign dev_wdata   = r_wdata;
  assign dev_wmask   = r_wmask;
  assign err_pulse   = r_err_pulse;
  assign err_timeout = r_err_timeout;
  assign err_address = r_err_address;

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_interconnect.sv
// ============================================================================
// Module      : tb_cpu_bus_interconnect
// Description : Directed self-checking bench for cpu_bus_interconnect.
//               Device behaviour is driven by hand, cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_interconnect;

  localparam logic [31:0] C_ERR_RDATA = 32'hDEAD_BEEF;

  logic         sys_clk = 1'b0;
  logic         sys_reset;
  logic         bus_request;
  logic [31:0]  bus_address;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_wmask;
  logic         bus_ack;
  logic [31:0]  bus_rdata;
  logic [4:0]   dev_request;
  logic [31:0]  dev_address;
  logic [31:0]  dev_wdata;
  logic [3:0]   dev_wmask;
  logic [4:0]   dev_ack;
  logic [159:0] dev_rdata;
  logic         err_pulse;
  logic         err_timeout;
  logic [31:0]  err_address;

  int n_assert = 0;
  int n_fail   = 0;

  cpu_bus_interconnect #(
    .TIMEOUT_CYCLES (16),
    .ERROR_RDATA    (C_ERR_RDATA)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .bus_request (bus_request),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_wmask   (bus_wmask),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .dev_request (dev_request),
    .dev_address (dev_address),
    .dev_wdata   (dev_wdata),
    .dev_wmask   (dev_wmask),
    .dev_ack     (dev_ack),
    .dev_rdata   (dev_rdata),
    .err_pulse   (err_pulse),
    .err_timeout (err_timeout),
    .err_address (err_address)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    bus_request = 1'b1;
    bus_address = addr;
    bus_wdata   = wd;
    bus_wmask   = wm;
  endtask

  initial begin
    sys_reset   = 1'b1;
    bus_request = 1'b0;
    bus_address = '0;
    bus_wdata   = '0;
    bus_wmask   = '0;
    dev_ack     = '0;
    dev_rdata   = '0;
    tick();
    tick();
    sys_reset = 1'b0;

    // Reset values
    check("rst_ack",      32'(bus_ack), 32'h0);
    check("rst_rdata",    bus_rdata, 32'h0);
    check("rst_devreq",   32'(dev_request), 32'h0);
    check("rst_err",      32'({err_pulse, err_timeout}), 32'h0);
    check("rst_erraddr",  err_address, 32'h0);
    check("rst_devaddr",  dev_address, 32'h0);

    // dev_ack while idle is ignored
    dev_ack = 5'b11111;
    tick();
    dev_ack = '0;
    check("idle_ack_devreq", 32'(dev_request), 32'h0);
    check("idle_ack_busack", 32'(bus_ack), 32'h0);

    // Bootloader read, device acks one cycle after request -> bus ack in cycle 3
    start(32'hF000_0008, 32'h0, 4'h0);              // cycle 0
    tick();                                          // cycle 1
    check("boot_devreq_c1", 32'(dev_request), 32'h10);
    check("boot_ack_c1",    32'(bus_ack), 32'h0);
    tick();                                          // cycle 2
    dev_ack = 5'b10000;
    dev_rdata[4*32 +: 32] = 32'h5000_0637;
    check("boot_devreq_c2", 32'(dev_request), 32'h10);
    check("boot_ack_c2",    32'(bus_ack), 32'h0);
    tick();                                          // cycle 3
    dev_ack = '0;
    check("boot_ack_c3",    32'(bus_ack), 32'h1);
    check("boot_rdata",     bus_rdata, 32'h5000_0637);
    check("boot_devreq_c3", 32'(dev_request), 32'h0);
    check("boot_err",       32'(err_pulse), 32'h0);
    bus_request = 1'b0;
    tick();
    check("boot_ack_c4",    32'(bus_ack), 32'h0);

    // RAM write
    start(32'h0000_0100, 32'hCAFE_F00D, 4'hF);
    tick();
    check("wr_devreq", 32'(dev_request), 32'h01);
    check("wr_addr",   dev_address, 32'h0000_0100);
    check("wr_wdata",  dev_wdata, 32'hCAFE_F00D);
    check("wr_wmask",  32'(dev_wmask), 32'hF);
    dev_ack = 5'b00001;
    tick();
    dev_ack = '0;
    check("wr_ack",    32'(bus_ack), 32'h1);
    bus_request = 1'b0;
    tick();
    check("wr_ack_once", 32'(bus_ack), 32'h0);

    // Unmapped read: ack in cycle 1 with error response
    start(32'h3000_0000, 32'h0, 4'h0);
    tick();
    check("um_ack",     32'(bus_ack), 32'h1);
    check("um_rdata",   bus_rdata, C_ERR_RDATA);
    check("um_pulse",   32'(err_pulse), 32'h1);
    check("um_timeout", 32'(err_timeout), 32'h0);
    check("um_erraddr", err_address, 32'h3000_0000);
    check("um_devreq",  32'(dev_request), 32'h0);
    bus_request = 1'b0;
    tick();
    check("um_pulse_off", 32'(err_pulse), 32'h0);
    check("um_ack_off",   32'(bus_ack), 32'h0);
    check("um_erraddr_hold", err_address, 32'h3000_0000);

    // Stray ack from CFG during RAM access, then reset mid-ACCESS
    start(32'h0000_0040, 32'h0, 4'h0);
    tick();
    check("stray_devreq_c1", 32'(dev_request), 32'h01);
    dev_ack = 5'b00100;
    tick();
    check("stray_devreq_c2", 32'(dev_request), 32'h01);
    check("stray_ack",       32'(bus_ack), 32'h0);
    dev_ack = 5'b00001;
    dev_rdata[0 +: 32] = 32'h0BAD_0BAD;
    sys_reset = 1'b1;
    tick();
    sys_reset   = 1'b0;
    dev_ack     = '0;
    bus_request = 1'b0;
    check("midrst_devreq",  32'(dev_request), 32'h0);
    check("midrst_ack",     32'(bus_ack), 32'h0);
    check("midrst_rdata",   bus_rdata, 32'h0);
    check("midrst_erraddr", err_address, 32'h0);
    check("midrst_devaddr", dev_address, 32'h0);
    tick();
    check("midrst_ack_after", 32'(bus_ack), 32'h0);

    // Back-to-back reads: RAM then UART; request held into RESPOND is ignored
    start(32'h0000_0000, 32'h0, 4'h0);
    tick();                                          // c1 ACCESS
    dev_ack = 5'b00001;
    dev_rdata[0 +: 32] = 32'h1111_1111;
    tick();                                          // c2 RESPOND
    dev_ack = '0;
    check("b2b_ack1",   32'(bus_ack), 32'h1);
    check("b2b_rdata1", bus_rdata, 32'h1111_1111);
    start(32'h5000_0000, 32'h0, 4'h0);
    tick();                                          // c3 IDLE accepts
    check("b2b_idle_ack",    32'(bus_ack), 32'h0);
    check("b2b_idle_devreq", 32'(dev_request), 32'h0);
    tick();                                          // c4 ACCESS
    check("b2b_devreq2", 32'(dev_request), 32'h08);
    dev_ack = 5'b01000;
    dev_rdata[3*32 +: 32] = 32'h2222_2222;
    tick();                                          // c5 RESPOND
    dev_ack = '0;
    bus_request = 1'b0;
    check("b2b_ack2",   32'(bus_ack), 32'h1);
    check("b2b_rdata2", bus_rdata, 32'h2222_2222);
    tick();
    check("b2b_ack2_off", 32'(bus_ack), 32'h0);

`ifdef CPU_BUS_TIMEOUT_EN
    // UART never acks: dev_request held for 16 cycles, then timeout error
    start(32'h5000_0010, 32'h0, 4'h0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("to_devreq_hold", 32'(dev_request), 32'h08);
      check("to_noack",       32'(bus_ack), 32'h0);
    end
    tick();
    check("to_devreq_drop", 32'(dev_request), 32'h0);
    check("to_ack",         32'(bus_ack), 32'h1);
    check("to_rdata",       bus_rdata, C_ERR_RDATA);
    check("to_pulse",       32'(err_pulse), 32'h1);
    check("to_timeout",     32'(err_timeout), 32'h1);
    check("to_erraddr",     err_address, 32'h5000_0010);
    bus_request = 1'b0;
    tick();
    check("to_timeout_hold", 32'(err_timeout), 32'h1);

    // Ack in the expiry cycle wins
    start(32'h5000_0020, 32'h0, 4'h0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 16) begin
        dev_ack = 5'b01000;
        dev_rdata[3*32 +: 32] = 32'h3333_3333;
      end
    end
    tick();
    dev_ack = '0;
    bus_request = 1'b0;
    check("race_ack",     32'(bus_ack), 32'h1);
    check("race_rdata",   bus_rdata, 32'h3333_3333);
    check("race_pulse",   32'(err_pulse), 32'h0);
    check("race_erraddr", err_address, 32'h5000_0010);
    tick();
`else
    // Without the watchdog, an unacknowledged access waits indefinitely
    start(32'h5000_0010, 32'h0, 4'h0);
    for (int i = 1; i <= 40; i++) begin
      tick();
    end
    check("nto_devreq_hold", 32'(dev_request), 32'h08);
    check("nto_noack",       32'(bus_ack), 32'h0);
    check("nto_pulse",       32'(err_pulse), 32'h0);
    dev_ack = 5'b01000;
    dev_rdata[3*32 +: 32] = 32'h4444_4444;
    tick();
    dev_ack = '0;
    bus_request = 1'b0;
    check("nto_ack",       32'(bus_ack), 32'h1);
    check("nto_rdata",     bus_rdata, 32'h4444_4444);
    check("nto_timeout",   32'(err_timeout), 32'h0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
